sprite_fetch_sched: RTL and testbench

Per-line sprite graphics fetch scheduler between the sprite sorter and `sprite_man`, replacing the fixed pixel-column decode of fetch index and data-valid strobes. After the horizontal sort window it issues one sprite-RAM word read per cycle for every sorted slot. Each slot needs two words, and the read pipeline is configurable. It delivers per-word capture strobes aligned to the RAM read latency. If the line ends before fetching completes, it aborts and raises a sticky overrun flag.

---
 rtl/sprite_fetch_sched_if.sv | 28 ++
 rtl/sprite_fetch_sched.sv | 174 +++++++++++++++++
 tb/tb_sprite_fetch_sched.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_fetch_sched_if.sv
// sprite_fetch_sched_if: bundles the pixel-column input, sorter slot mask,
// sprite-RAM read request, capture strobes and status of the fetch scheduler.
// master = driver of the scheduler (dtg/sorter/sprite_man side),
// slave  = the scheduler itself.
interface sprite_fetch_sched_if #(
  parameter int NUM_SLOTS = 16
);
  logic [11:0]          pix_col;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic                 overrun_clr;
  logic                 rd_req;
  logic [3:0]           rd_index;
  logic                 rd_word;
  logic [3:0]           cap_index;
  logic [1:0]           cap_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output pix_col, slot_valid, overrun_clr,
    input  rd_req, rd_index, rd_word, cap_index, cap_valid, busy, overrun
  );

  modport slave (
    input  pix_col, slot_valid, overrun_clr,
    output rd_req, rd_index, rd_word, cap_index, cap_valid, busy, overrun
  );
endinterface

// File: rtl/sprite_fetch_sched.sv
// sprite_fetch_sched: per-line sprite graphics fetch scheduler.
// After the sort window (pix_col == START_COL) it issues one sprite-RAM word
// read per cycle, two words per slot, and returns capture strobes delayed by
// RD_LATENCY. Reaching pix_col == H_TOTAL-1 while still issuing aborts the
// fetch and sets the sticky overrun flag; in-flight words are still delivered.
// Optional feature macro: SPRITE_FETCH_SKIP_EN -- when defined, slots whose
// slot_valid bit is 0 are skipped in zero cycles; when undefined, every slot
// is fetched regardless of slot_valid.
module sprite_fetch_sched #(
  parameter int NUM_SLOTS  = 16,
  parameter int START_COL  = 704,
  parameter int H_TOTAL    = 800,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  sprite_fetch_sched_if.slave   sif
);

  localparam logic [11:0] START_COL_C = 12'(START_COL);
  localparam logic [11:0] LAST_COL_C  = 12'(H_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic       word_q, word_d;
  logic       overrun_q, overrun_d;
  logic       issue;
  logic       abort;

  // Read-latency delay line: one {valid, index, word} entry per stage.
  logic [RD_LATENCY-1:0]       dl_valid_q, dl_valid_d;
  logic [RD_LATENCY-1:0][3:0]  dl_index_q, dl_index_d;
  logic [RD_LATENCY-1:0]       dl_word_q, dl_word_d;
  logic                        dl_empty;

`ifdef SPRITE_FETCH_SKIP_EN
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [4:0]           first_hit;
  logic [4:0]           next_hit;

  // Lowest set mask bit at or above 'from'; returns {found, index}.
  function automatic logic [4:0] find_next(input logic [NUM_SLOTS-1:0] m,
                                           input logic [4:0] from);
    logic [4:0] hit;
    hit = 5'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (m[i] && (5'(i) >= from)) hit = {1'b1, 4'(i)};
    end
    return hit;
  endfunction

  assign first_hit = find_next(sif.slot_valid, 5'd0);
  assign next_hit  = find_next(mask_q, {1'b0, slot_q} + 5'd1);
`else
  localparam logic [3:0] LAST_SLOT_C = 4'(NUM_SLOTS - 1);
  // Every slot is fetched; the sorter mask has no effect in this build.
  logic unused_slot_valid;
  assign unused_slot_valid = ^sif.slot_valid;
`endif

  assign dl_empty = ~|dl_valid_q;

  // Next-state and issue decision for the fetch FSM.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    word_d  = word_q;
    issue   = 1'b0;
    abort   = 1'b0;
`ifdef SPRITE_FETCH_SKIP_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sif.pix_col == START_COL_C) begin
          word_d = 1'b0;
`ifdef SPRITE_FETCH_SKIP_EN
          mask_d = sif.slot_valid;
          slot_d = first_hit[3:0];
          state_d = first_hit[4] ? ST_ISSUE : ST_DRAIN;
`else
          slot_d  = 4'd0;
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        if (sif.pix_col == LAST_COL_C) begin
          abort   = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          issue = 1'b1;
          if (!word_q) begin
            word_d = 1'b1;
          end else begin
            word_d = 1'b0;
`ifdef SPRITE_FETCH_SKIP_EN
            if (next_hit[4]) slot_d = next_hit[3:0];
            else             state_d = ST_DRAIN;
`else
            if (slot_q == LAST_SLOT_C) state_d = ST_DRAIN;
            else                       slot_d = slot_q + 4'd1;
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (dl_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overrun: a new abort wins over a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (abort)                overrun_d = 1'b1;
    else if (sif.overrun_clr) overrun_d = 1'b0;
  end

  // Stage 0 takes the issue decision; later stages shift the previous one.
  assign dl_valid_d[0] = issue;
  assign dl_index_d[0] = slot_q;
  assign dl_word_d[0]  = word_q;
  for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
    assign dl_valid_d[gi] = dl_valid_q[gi-1];
    assign dl_index_d[gi] = dl_index_q[gi-1];
    assign dl_word_d[gi]  = dl_word_q[gi-1];
  end

  // State, counters, overrun flag and delay line registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      slot_q     <= 4'd0;
      word_q     <= 1'b0;
      overrun_q  <= 1'b0;
      dl_valid_q <= '0;
      dl_index_q <= '0;
      dl_word_q  <= '0;
`ifdef SPRITE_FETCH_SKIP_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      word_q     <= word_d;
      overrun_q  <= overrun_d;
      dl_valid_q <= dl_valid_d;
      dl_index_q <= dl_index_d;
      dl_word_q  <= dl_word_d;
`ifdef SPRITE_FETCH_SKIP_EN
      mask_q     <= mask_d;
`endif
    end
  end

  assign sif.rd_req    = issue;
  assign sif.rd_index  = issue ? slot_q : 4'd0;
  assign sif.rd_word   = issue & word_q;
  assign sif.cap_valid = dl_valid_q[RD_LATENCY-1]
                         ? {dl_word_q[RD_LATENCY-1], ~dl_word_q[RD_LATENCY-1]}
                         : 2'b00;
  assign sif.cap_index = dl_valid_q[RD_LATENCY-1] ? dl_index_q[RD_LATENCY-1] : 4'd0;
  assign sif.busy      = (state_q != ST_IDLE) && !((state_q == ST_DRAIN) && dl_empty);
  assign sif.overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Testbench for sprite_fetch_sched. Three instances share one pixel column:
//   dut0: H_TOTAL=800, RD_LATENCY=2 (defaults)
//   dut1: H_TOTAL=720, RD_LATENCY=2 (deadline abort every full line)
//   dut2: H_TOTAL=800, RD_LATENCY=4
// Expected requests/captures are pushed into queues when a line's mask is
// applied; a negedge monitor pops and compares whenever a DUT shows rd_req or
// cap_valid. Honours SPRITE_FETCH_SKIP_EN the same way as the design.
module tb_sprite_fetch_sched;
  localparam int START = 704;
  localparam int ND    = 3;
`ifdef SPRITE_FETCH_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    int         dut;
    int         line;
    int         col;
    logic [3:0] idx;
    logic       w;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] pix_col;
  logic [15:0] slot_valid;
  logic        overrun_clr;

  exp_t exp_req[$];
  exp_t exp_cap[$];
  int   checks = 0;
  int   errors = 0;
  int   line_no = 0;
  bit   mon_en = 1'b0;
  bit   ovr_m[ND];
  bit   abort_m[ND];
  int   nreq_m[ND];

  always #10 clk = ~clk;

  sprite_fetch_sched_if #(.NUM_SLOTS(16)) if_a ();
  sprite_fetch_sched_if #(.NUM_SLOTS(16)) if_b ();
  sprite_fetch_sched_if #(.NUM_SLOTS(16)) if_c ();

  assign if_a.pix_col = pix_col;  assign if_a.slot_valid = slot_valid;  assign if_a.overrun_clr = overrun_clr;
  assign if_b.pix_col = pix_col;  assign if_b.slot_valid = slot_valid;  assign if_b.overrun_clr = overrun_clr;
  assign if_c.pix_col = pix_col;  assign if_c.slot_valid = slot_valid;  assign if_c.overrun_clr = overrun_clr;

  sprite_fetch_sched #(.NUM_SLOTS(16), .START_COL(704), .H_TOTAL(800), .RD_LATENCY(2))
    u_dut0 (.clk(clk), .resetn(resetn), .sif(if_a));
  sprite_fetch_sched #(.NUM_SLOTS(16), .START_COL(704), .H_TOTAL(720), .RD_LATENCY(2))
    u_dut1 (.clk(clk), .resetn(resetn), .sif(if_b));
  sprite_fetch_sched #(.NUM_SLOTS(16), .START_COL(704), .H_TOTAL(800), .RD_LATENCY(4))
    u_dut2 (.clk(clk), .resetn(resetn), .sif(if_c));

  function automatic int ht_of(int d);
    return (d == 1) ? 720 : 800;
  endfunction

  function automatic int lat_of(int d);
    return (d == 2) ? 4 : 2;
  endfunction

  // {rd_req, rd_index, rd_word, cap_index, cap_valid, busy, overrun}
  function automatic logic [13:0] outs(int d);
    case (d)
      0: return {if_a.rd_req, if_a.rd_index, if_a.rd_word, if_a.cap_index, if_a.cap_valid, if_a.busy, if_a.overrun};
      1: return {if_b.rd_req, if_b.rd_index, if_b.rd_word, if_b.cap_index, if_b.cap_valid, if_b.busy, if_b.overrun};
      2: return {if_c.rd_req, if_c.rd_index, if_c.rd_word, if_c.cap_index, if_c.cap_valid, if_c.busy, if_c.overrun};
      default: return '0;
    endcase
  endfunction

  task automatic chk(string what, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d line%0d col%0d: got %0h expected %0h", what, d, line_no, pix_col, act, exp);
    end
  endtask

  function automatic int find_first(bit is_cap, int d);
    if (is_cap) begin
      for (int i = 0; i < exp_cap.size(); i++) if (exp_cap[i].dut == d) return i;
    end else begin
      for (int i = 0; i < exp_req.size(); i++) if (exp_req[i].dut == d) return i;
    end
    return -1;
  endfunction

  function automatic bit is_past(exp_t e);
    return (e.line < line_no) || ((e.line == line_no) && (e.col < int'(pix_col)));
  endfunction

  // Reference: list the (slot, word) fetches of the line in order, one per
  // column from START+1, stopping at the deadline column H_TOTAL-1.
  task automatic predict(int d, logic [15:0] mask);
    int  n;
    int  col;
    bit  ab;
    exp_t e;
    n  = 0;
    ab = 1'b0;
    for (int s = 0; s < 16; s++) begin
      if (SKIP && !mask[s]) continue;
      for (int w = 0; w < 2; w++) begin
        col = START + 1 + n;
        if (col == ht_of(d) - 1) begin
          ab = 1'b1;
          break;
        end
        e.dut = d; e.line = line_no; e.col = col; e.idx = 4'(s); e.w = w[0];
        exp_req.push_back(e);
        e.col = col + lat_of(d);
        exp_cap.push_back(e);
        n++;
      end
      if (ab) break;
    end
    abort_m[d] = ab;
    nreq_m[d]  = n;
  endtask

  task automatic mon_one(int d);
    logic [13:0] o;
    int          k;
    exp_t        e;
    o = outs(d);
    // Expected transactions whose slot has already passed were missed.
    k = find_first(1'b0, d);
    while (k >= 0 && is_past(exp_req[k])) begin
      chk("missed_req", d, 0, 1);
      exp_req.delete(k);
      k = find_first(1'b0, d);
    end
    k = find_first(1'b1, d);
    while (k >= 0 && is_past(exp_cap[k])) begin
      chk("missed_cap", d, 0, 1);
      exp_cap.delete(k);
      k = find_first(1'b1, d);
    end
    if (o[13]) begin
      k = find_first(1'b0, d);
      if (k < 0) chk("unexpected_req", d, 1, 0);
      else begin
        e = exp_req[k];
        exp_req.delete(k);
        chk("req_col", d, 32'(pix_col), 32'(e.col));
        chk("req_index", d, 32'(o[12:9]), 32'(e.idx));
        chk("req_word", d, 32'(o[8]), 32'(e.w));
      end
    end
    if (o[3:2] != 2'b00) begin
      k = find_first(1'b1, d);
      if (k < 0) chk("unexpected_cap", d, 32'(o[3:2]), 0);
      else begin
        e = exp_cap[k];
        exp_cap.delete(k);
        chk("cap_col", d, 32'(pix_col), 32'(e.col));
        chk("cap_index", d, 32'(o[7:4]), 32'(e.idx));
        chk("cap_valid", d, 32'(o[3:2]), e.w ? 32'd2 : 32'd1);
      end
    end
  endtask

  // Monitor: compare every presented request/capture against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < ND; d++) mon_one(d);
    end
  end

  task automatic drop_after(int col);
    for (int i = exp_req.size() - 1; i >= 0; i--)
      if (exp_req[i].line == line_no && exp_req[i].col >= col) exp_req.delete(i);
    for (int i = exp_cap.size() - 1; i >= 0; i--)
      if (exp_cap[i].line == line_no && exp_cap[i].col >= col) exp_cap.delete(i);
  endtask

  task automatic run_line(logic [15:0] mask, bit clr_early, bit clr_late, bit do_rst);
    line_no++;
    slot_valid = mask;
    for (int d = 0; d < ND; d++) predict(d, mask);
    $display("line %0d mask=%04h reqs=%0d/%0d/%0d abort=%0d clr=%0d%0d rst=%0d",
             line_no, mask, nreq_m[0], nreq_m[1], nreq_m[2], abort_m[1], clr_early, clr_late, do_rst);
    for (int col = 690; col < 800; col++) begin
      pix_col     = 12'(col);
      overrun_clr = (col == 695 && clr_early) || (col == 719 && clr_late);
      if (do_rst && col == 712) resetn = 1'b0;
      if (do_rst && col == 715) resetn = 1'b1;
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        logic [13:0] o;
        o = outs(d);
        if (col == 704) chk("busy_at_start", d, 32'(o[1]), 0);
        if (col == 705) chk("busy_first_req", d, 32'(o[1]), 32'(nreq_m[d] > 0));
        if (col == 719) chk("overrun_deadline", d, 32'(o[0]), 32'(ovr_m[d]));
        if (col == 760) chk("busy_done", d, 32'(o[1]), 0);
        if (do_rst && col == 712) chk("reset_outs", d, 32'(o), 0);
      end
      if (do_rst && col == 712) begin
        drop_after(712);
        for (int d = 0; d < ND; d++) begin ovr_m[d] = 1'b0; abort_m[d] = 1'b0; end
      end
      if (col == 695 && clr_early)
        for (int d = 0; d < ND; d++) ovr_m[d] = 1'b0;
      if (col == 719)
        for (int d = 0; d < ND; d++) ovr_m[d] = abort_m[d] ? 1'b1 : (clr_late ? 1'b0 : ovr_m[d]);
      if (col == 720)
        for (int d = 0; d < ND; d++) begin
          logic [13:0] o2;
          o2 = outs(d);
          chk("overrun_after", d, 32'(o2[0]), 32'(ovr_m[d]));
        end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] m;
    resetn      = 1'b0;
    pix_col     = 12'd0;
    slot_valid  = 16'h0;
    overrun_clr = 1'b0;
    for (int d = 0; d < ND; d++) begin ovr_m[d] = 1'b0; abort_m[d] = 1'b0; nreq_m[d] = 0; end
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) chk("reset_state", d, 32'(outs(d)), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;
    run_line(16'hFFFF, 1'b0, 1'b1, 1'b0);   // overrun set and clear together
    run_line(16'h8001, 1'b1, 1'b0, 1'b0);
    run_line(16'h0000, 1'b0, 1'b0, 1'b0);
    run_line(16'hFFFF, 1'b0, 1'b0, 1'b1);   // reset mid-fetch
    run_line(16'hFFFF, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 8; l++) begin
      m = 16'($urandom);
      if (l[0]) m = m & 16'($urandom);
      run_line(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    mon_en = 1'b0;
    chk("leftover_expected", 0, 32'(exp_req.size() + exp_cap.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
